// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer : Miyamii-4000 fetch/decode/FIN sequencer and exec handoff |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int PC_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                rom_req,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [7:0]          rom_data,
  input  logic                rom_ack,
  output logic [7:0]          dec_instr,
  output logic                dec_first_byte,
  input  logic                dec_is_two_byte,
  input  logic [7:0]          fin_addr,
  output logic [7:0]          ir2,
  output logic [PC_WIDTH-1:0] pc,
  output logic                exec_valid,
  input  logic                exec_done,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic                busy
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH1 = 3'd1,
    S_DECODE = 3'd2,
    S_FETCH2 = 3'd3,
    S_FIN_RD = 3'd4,
    S_EXEC   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir1_q, ir1_d;
  logic [7:0]          ir2_q, ir2_d;
  logic                is_fin;

  // FIN is the even opcode in the 0x3_ row; odd ones are JIN and execute directly.
  assign is_fin = (ir1_q[7:4] == 4'b0011) && !ir1_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir1_q   <= '0;
      ir2_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH1;
      end
      S_FETCH1: begin
        if (rom_ack) begin
          ir1_d   = rom_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_is_two_byte)  state_d = S_FETCH2;
        else if (is_fin)      state_d = S_FIN_RD;
        else                  state_d = S_EXEC;
      end
      S_FETCH2: begin
        if (rom_ack) begin
          ir2_d   = rom_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_EXEC;
        end
      end
      S_FIN_RD: begin
        // Indirect data read; the pc already points past the FIN opcode.
        if (rom_ack) begin
          ir2_d   = rom_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          if (jump_en) pc_d = jump_addr;
          state_d = run ? S_FETCH1 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_req        = (state_q == S_FETCH1) || (state_q == S_FETCH2) ||
                          (state_q == S_FIN_RD);
  assign rom_addr       = (state_q == S_FIN_RD) ? {pc_q[PC_WIDTH-1:8], fin_addr} : pc_q;
  assign dec_first_byte = (state_q == S_DECODE) || (state_q == S_FETCH2) ||
                          (state_q == S_FIN_RD) || (state_q == S_EXEC);
  assign exec_valid     = (state_q == S_EXEC);
  assign busy           = (state_q != S_IDLE);
  assign dec_instr      = ir1_q;
  assign ir2            = ir2_q;
  assign pc             = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer : randomized bench with an instruction-level model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        rom_req;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_ack = 1'b0;
  logic [7:0]  dec_instr;
  logic        dec_first_byte;
  logic        dec_is_two_byte;
  logic [7:0]  fin_addr = 8'h00;
  logic [7:0]  ir2;
  logic [11:0] pc;
  logic        exec_valid;
  logic        exec_done = 1'b0;
  logic        jump_en = 1'b0;
  logic [11:0] jump_addr = 12'h000;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  rom [4096];
  logic [11:0] model_pc;
  logic [7:0]  model_ir2;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ack(rom_ack),
    .dec_instr(dec_instr), .dec_first_byte(dec_first_byte),
    .dec_is_two_byte(dec_is_two_byte), .fin_addr(fin_addr), .ir2(ir2), .pc(pc),
    .exec_valid(exec_valid), .exec_done(exec_done), .jump_en(jump_en),
    .jump_addr(jump_addr), .busy(busy)
  );

  // Stand-in decoder: JCN/FIM/JUN/JMS/ISZ rows are two-byte.
  function automatic bit is_two(input logic [7:0] b);
    return (b[7:4] == 4'h1) || (b[7:4] == 4'h4) || (b[7:4] == 4'h5) ||
           (b[7:4] == 4'h7) || ((b[7:4] == 4'h2) && !b[0]);
  endfunction

  function automatic bit is_fin(input logic [7:0] b);
    return (b[7:4] == 4'h3) && !b[0];
  endfunction

  assign dec_is_two_byte = is_two(dec_instr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete instruction starting at model_pc, acting as ROM and execute stage.
  task automatic do_instr(input int w1, input int w2, input int stall, input bit jmp,
                          input logic [11:0] jaddr, input bit keep_run,
                          input logic [7:0] fa);
    logic [11:0] p, p1, p_next, a2, cur_addr;
    logic [7:0]  b1, exp_ir2;
    logic [11:0] exp_addr[$];
    bit          two, fin, in_req, seen_exec, done;
    int          exp_cyc, cyc, nreq, wl, st, iter;
    p    = model_pc;
    p1   = p + 12'd1;
    b1   = rom[p];
    two  = is_two(b1);
    fin  = !two && is_fin(b1);
    exp_addr.push_back(p);
    if (two) begin
      exp_addr.push_back(p1);
      exp_ir2 = rom[p1];
      p_next  = p1 + 12'd1;
    end else if (fin) begin
      a2 = {p1[11:8], fa};
      exp_addr.push_back(a2);
      exp_ir2 = rom[a2];
      p_next  = p1;
    end else begin
      exp_ir2 = model_ir2;
      p_next  = p1;
    end
    exp_cyc = 3 + w1 + stall + ((two || fin) ? (1 + w2) : 0);
    cyc = 0; nreq = 0; wl = 0; st = 0; iter = 0;
    in_req = 0; seen_exec = 0; done = 0; cur_addr = '0;
    fin_addr = fa;
    run = 1'b1;
    while (!done && iter < 100) begin
      @(negedge clk);
      iter++;
      rom_ack   = 1'b0;
      exec_done = 1'b0;
      jump_en   = 1'b0;
      rom_data  = 8'($urandom);
      if (busy) cyc++;
      if (rom_req) begin
        if (!in_req) begin
          if (nreq < exp_addr.size()) check("req_addr", 32'(rom_addr), 32'(exp_addr[nreq]));
          else check("req_count_over", nreq + 1, exp_addr.size());
          in_req   = 1;
          cur_addr = rom_addr;
          wl       = (nreq == 0) ? w1 : w2;
          nreq++;
        end else begin
          check("addr_stable", 32'(rom_addr), 32'(cur_addr));
        end
        if (wl == 0) begin
          rom_ack  = 1'b1;
          rom_data = rom[rom_addr];
          in_req   = 0;
        end else begin
          wl--;
        end
      end else begin
        rom_ack = 1'($urandom);
      end
      if (exec_valid) begin
        check("exec_ir1", 32'(dec_instr), 32'(b1));
        check("exec_ir2", 32'(ir2), 32'(exp_ir2));
        check("exec_pc", 32'(pc), 32'(p_next));
        if (!seen_exec) begin
          seen_exec = 1;
          st = stall;
          check("exec_dfb", 32'(dec_first_byte), 32'd1);
          check("exec_rom_req", 32'(rom_req), 32'd0);
        end
        if (st == 0) begin
          exec_done = 1'b1;
          jump_en   = jmp;
          jump_addr = jaddr;
          run       = keep_run;
          done      = 1;
        end else begin
          st--;
        end
      end else begin
        exec_done = 1'($urandom);
        jump_en   = 1'($urandom);
        jump_addr = 12'($urandom);
      end
    end
    check("exec_reached", 32'(done), 32'd1);
    check("req_count", nreq, exp_addr.size());
    check("cycles", cyc, exp_cyc);
    model_pc  = jmp ? jaddr : p_next;
    model_ir2 = exp_ir2;
  endtask

  // Stray handshakes while idle must not move state or pc.
  task automatic idle_stray();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rom_ack   = 1'b1;
      exec_done = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 12'hFFF;
      rom_data  = 8'h12;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_req", 32'(rom_req), 32'd0);
      check("idle_valid", 32'(exec_valid), 32'd0);
      check("idle_pc", 32'(pc), 32'(model_pc));
    end
    @(negedge clk);
    rom_ack = 1'b0; exec_done = 1'b0; jump_en = 1'b0;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    model_pc  = 12'h000;
    model_ir2 = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst_req", 32'(rom_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(exec_valid), 32'd0);
    check("rst_dfb", 32'(dec_first_byte), 32'd0);
    check("rst_ir1", 32'(dec_instr), 32'd0);
    check("rst_ir2", 32'(ir2), 32'd0);
    rst_n = 1'b1;

    // Reset asserted mid-FETCH2 with the request outstanding
    rom[12'h000] = 8'h4A;
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      rom_ack = 1'b0;
      if (rom_req && dec_first_byte) found = 1;
      else if (rom_req) begin
        rom_ack  = 1'b1;
        rom_data = rom[rom_addr];
      end
    end
    check("f2_reached", 32'(found), 32'd1);
    check("f2_pc", 32'(pc), 32'h001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(rom_req), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_valid", 32'(exec_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ir1", 32'(dec_instr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed programme
    rom[12'h000] = 8'hD5;
    rom[12'h001] = 8'hD1;
    rom[12'h010] = 8'h4A;
    rom[12'h011] = 8'hBC;
    rom[12'hABC] = 8'hD0;
    rom[12'h2FF] = 8'h30;
    rom[12'hFFF] = 8'hD7;
    do_instr(0, 0, 0, 1'b0, 12'h000, 1'b1, 8'h00);  // LDM 5 at 0x000
    do_instr(0, 0, 0, 1'b1, 12'h010, 1'b1, 8'h00);  // jump to 0x010
    do_instr(2, 2, 0, 1'b1, 12'hABC, 1'b1, 8'h00);  // JUN with wait states
    do_instr(0, 0, 0, 1'b1, 12'h2FF, 1'b1, 8'h00);
    do_instr(0, 0, 0, 1'b1, 12'hFFF, 1'b1, 8'h34);  // FIN across page
    do_instr(0, 0, 4, 1'b0, 12'h000, 1'b1, 8'h00);  // wrap + exec stall
    do_instr(1, 0, 0, 1'b0, 12'h000, 1'b0, 8'h00);  // drop run
    idle_stray();

    // Randomized programme
    for (int k = 0; k < 60; k++) begin
      do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
               12'($urandom), ($urandom_range(0, 5) != 0), 8'($urandom));
      if (!run) idle_stray();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch/execute sequencer for the Miyamii-4000 core. Owns the 12-bit program counter and drives the ROM fetch handshake. Holds the first and second instruction bytes, and presents the first byte to the instruction decoder. It uses the decoder's two-byte indication to fetch a second byte, performs the FIN indirect fetch, and hands each complete instruction to the execute stage with a valid/done handshake.

## Interface
- PC_WIDTH, 12, program counter and ROM address width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  enable; sampled only in IDLE and at instruction completion
- rom_req  out  1  ROM read request, held until rom_ack
- rom_addr  out  PC_WIDTH  ROM byte address, stable while rom_req=1
- rom_data  in  8  ROM byte, valid in the cycle rom_ack=1
- rom_ack  in  1  ROM read complete; ignored when rom_req=0
- dec_instr  out  8  first instruction byte (ir1), to decoder
- dec_first_byte  out  1  decoder qualify; high in DECODE, FETCH2, FIN_RD, EXEC
- dec_is_two_byte  in  1  from decoder, combinational on dec_instr
- fin_addr  in  8  register-pair contents for FIN, valid during FIN_RD
- ir2  out  8  second byte (two-byte operand or FIN data)
- pc  out  PC_WIDTH  current program counter
- exec_valid  out  1  instruction ready for execute stage
- exec_done  in  1  execute stage finished; only honoured while exec_valid=1
- jump_en  in  1  load jump_addr into pc; only honoured with exec_done
- jump_addr  in  PC_WIDTH  jump target
- busy  out  1  high in every state except IDLE

## Operation
- The state machine has six states: IDLE, FETCH1, DECODE, FETCH2, FIN_RD, EXEC.
- **IDLE:** if run=1, go to FETCH1, otherwise stay.
- **FETCH1:** rom_req=1, rom_addr=pc.
  - On rom_ack: ir1<=rom_data, pc<=pc+1, go to DECODE.
- **DECODE:** one cycle; the decoder evaluates ir1.
  - If dec_is_two_byte=1, go to FETCH2.
  - Else, if ir1[7:4]=4'b0011 and ir1[0]=0 (FIN), go to FIN_RD.
  - Else, go to EXEC.
- **FETCH2:** rom_req=1, rom_addr=pc.
  - On rom_ack: ir2<=rom_data, pc<=pc+1, go to EXEC.
- **FIN_RD:** rom_req=1, rom_addr={pc[11:8], fin_addr}. The pc has already been incremented, so this uses the page of the next instruction.
  - On rom_ack: ir2<=rom_data, go to EXEC. pc is not incremented.
- **EXEC:** exec_valid=1; ir1, ir2 and pc stay frozen.
  - On exec_done: if jump_en=1, pc<=jump_addr. Then, if run=1, go to FETCH1, else go to IDLE.
- One-byte instructions leave ir2 unchanged. The execute stage must not use ir2 for them.
- PC arithmetic is modulo 2^PC_WIDTH: incrementing 0xFFF gives 0x000. Page-relative jump targets are formed by the execute stage; jump_addr is used as a full address.
- jump_en with exec_done overrides the sequential pc.
- rom_ack, exec_done and jump_en arriving outside their honoured states have no effect.

## Timing
- Reset (async, rst_n=0) forces:
  - state=IDLE, pc=0, ir1=0, ir2=0;
  - rom_req=0, exec_valid=0, dec_first_byte=0, busy=0.
- Reset takes effect immediately, including mid-handshake. An outstanding ROM request is dropped. The ROM must tolerate rom_req falling without rom_ack.
- rom_req, rom_addr, exec_valid, dec_first_byte and busy are Moore outputs decoded from registered state; rom_addr also depends on the fin_addr input in FIN_RD. None depends combinationally on rom_ack or exec_done.
- Zero-wait ROM (rom_ack in the same cycle as rom_req) and exec_done in the first EXEC cycle give:
  - one-byte instruction: 3 cycles (FETCH1, DECODE, EXEC);
  - two-byte or FIN: 4 cycles.
  - Each ROM wait cycle or exec stall cycle adds exactly one cycle.
- Once rom_req=1, rom_addr holds constant until the acknowledging cycle.
- exec_valid stays high until exec_done; the next fetch starts the cycle after exec_done.
- run=0 takes effect only at instruction boundaries. It never aborts a fetch or an execution.

## Test plan
- **Reset:** assert rst_n=0 mid-FETCH2 with rom_req=1 -> the same cycle shows rom_req=0, pc=0x000, state=IDLE, exec_valid=0. After release with run=1, the first rom_addr is 0x000.
- **One-byte instruction:** ROM[0x000]=0xD5 (LDM 5), zero-wait ROM, exec_done immediate -> exec_valid high in cycle 3, dec_instr=0xD5, pc=0x001 in EXEC, next rom_req addr 0x001.
- **Jump with wait states:** JUN 0x4A,0xBC at 0x010 with 2 wait cycles per fetch; execute returns jump_en=1, jump_addr=0xABC -> FETCH2 addr=0x011, ir2=0xBC, pc=0x012 during EXEC, next fetch addr=0xABC, 8 cycles total.
- **FIN indirect fetch:** FIN (0x30) at pc=0x2FF, fin_addr=0x34 -> pc wraps page to 0x300, FIN_RD rom_addr=0x334, ir2 gets ROM[0x334], pc remains 0x300.
- **Wrap-around and execute stall:** one-byte instruction at 0xFFF -> pc=0x000 after FETCH1. exec_done delayed 4 cycles -> exec_valid high 5 cycles with ir1, ir2 and pc frozen.
- **Run control and stray handshakes:** run dropped during EXEC -> IDLE after exec_done, no rom_req, busy=0. rom_ack and exec_done pulsed in IDLE -> no state or pc change.
